// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: next-PC select encoding, default widths,
// and the branch-control FSM state type.
package pipe_pkg;

    // Default width of PC, BrA and RAA.
    localparam int ADDR_W_DEFAULT       = 16;
    // Default number of flush cycles per taken redirect (legal range 1..7).
    localparam int FLUSH_CYCLES_DEFAULT = 2;

    // BS encoding shared between EX and IF.
    localparam logic [1:0] BS_INC  = 2'b00;  // next PC = PC + 1
    localparam logic [1:0] BS_COND = 2'b01;  // branch to BrA when (Z ^ PS)
    localparam logic [1:0] BS_JMPR = 2'b10;  // jump to RAA
    localparam logic [1:0] BS_BR   = 2'b11;  // unconditional branch to BrA

    // Branch-control FSM states.
    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    // True when a decoded branch with these fields redirects the PC.
    function automatic logic bs_redirects(input logic [1:0] bs,
                                          input logic       ps,
                                          input logic       z);
        logic r;
        r = 1'b0;
        case (bs)
            BS_INC:  r = 1'b0;
            BS_COND: r = z ^ ps;
            BS_JMPR: r = 1'b1;
            BS_BR:   r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch outcome evaluator: given the EX entry's branch
// select, polarity, the live zero flag and the entry's valid bit, decides
// whether the PC is redirected this cycle.
module branch_cond
    import pipe_pkg::*;
(
    input  logic       i_valid,
    input  logic [1:0] i_bs,
    input  logic       i_ps,
    input  logic       i_z,
    output logic       o_taken
);

    // An invalid (squashed or empty) entry never redirects.
    always_comb begin
        o_taken = 1'b0;
        if (i_valid) begin
            o_taken = bs_redirects(i_bs, i_ps, i_z);
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// EX-stage branch resolution. Latches decoded branch fields from DOF,
// resolves them against the same-cycle EX zero flag and drives the IF
// next-PC select inputs. A taken redirect raises flush for FLUSH_CYCLES
// cycles so the wrong-path instructions in IF/DOF are squashed.
// stall freezes every piece of state, including the flush countdown.
// Optional statistics counters are compiled in with BRANCH_CTRL_STATS_EN.
module branch_ctrl
    import pipe_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEFAULT,
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              dof_valid,
    input  logic [1:0]        dof_bs,
    input  logic              dof_ps,
    input  logic [ADDR_W-1:0] dof_bra,
    input  logic [ADDR_W-1:0] dof_raa,
    input  logic              ex_z,
    output logic [1:0]        BS,
    output logic              PS,
    output logic              Z,
    output logic [ADDR_W-1:0] BrA,
    output logic [ADDR_W-1:0] RAA,
    output logic              taken,
    output state_e            o_dbg_state,
    output logic [2:0]        o_dbg_cnt,
    output logic              flush
`ifdef BRANCH_CTRL_STATS_EN
    ,
    output logic [15:0]       br_total,
    output logic [15:0]       br_taken,
    output logic [15:0]       flush_cyc
`endif
);

    // Countdown value loaded on entry to FLUSH: the taken cycle itself is
    // the first flush cycle, FLUSH covers the remaining ones.
    localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

    // EX register
    logic              r_ex_valid;
    logic [1:0]        r_ex_bs;
    logic              r_ex_ps;
    logic [ADDR_W-1:0] r_ex_bra;
    logic [ADDR_W-1:0] r_ex_raa;

    // FSM
    state_e            r_state;
    state_e            w_state_nxt;
    logic [2:0]        r_cnt;
    logic [2:0]        w_cnt_nxt;

    logic              w_taken;
    logic              w_flush;

    // Branch outcome, zero added latency from EX entry to redirect.
    branch_cond u_cond (
        .i_valid (r_ex_valid),
        .i_bs    (r_ex_bs),
        .i_ps    (r_ex_ps),
        .i_z     (ex_z),
        .o_taken (w_taken)
    );

    // EX register: capture DOF fields unless stalled; squash while flushing.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_valid <= 1'b0;
            r_ex_bs    <= BS_INC;
            r_ex_ps    <= 1'b0;
            r_ex_bra   <= '0;
            r_ex_raa   <= '0;
        end else if (!stall) begin
            r_ex_valid <= dof_valid & ~w_flush;
            r_ex_bs    <= dof_bs;
            r_ex_ps    <= dof_ps;
            r_ex_bra   <= dof_bra;
            r_ex_raa   <= dof_raa;
        end
    end

    // FSM state register; stall is folded into the next-state logic.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // FSM next-state and flush output. A redirect seen in FLUSH is ignored:
    // the EX entry there is always a squashed one.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_flush     = 1'b0;
        case (r_state)
            RUN: begin
                w_flush = w_taken;
                if (w_taken && !stall && (FLUSH_CYCLES > 1)) begin
                    w_state_nxt = FLUSH;
                    w_cnt_nxt   = CNT_INIT;
                end
            end
            FLUSH: begin
                w_flush = 1'b1;
                if (!stall) begin
                    w_cnt_nxt = r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        w_state_nxt = RUN;
                    end
                end
            end
            default: begin
                w_state_nxt = RUN;
                w_cnt_nxt   = 3'd0;
            end
        endcase
    end

    // Outputs to IF. BS and Z are masked by the EX valid bit so that an
    // empty or squashed slot always selects PC + 1.
    assign BS          = r_ex_valid ? r_ex_bs : BS_INC;
    assign PS          = r_ex_ps;
    assign Z           = ex_z & r_ex_valid;
    assign BrA         = r_ex_bra;
    assign RAA         = r_ex_raa;
    assign taken       = w_taken;
    assign flush       = w_flush;
    assign o_dbg_state = r_state;
    assign o_dbg_cnt   = r_cnt;

`ifdef BRANCH_CTRL_STATS_EN
    logic [15:0] r_br_total;
    logic [15:0] r_br_taken;
    logic [15:0] r_flush_cyc;

    // Event counters, advancing on non-stall cycles only and wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_br_total  <= 16'd0;
            r_br_taken  <= 16'd0;
            r_flush_cyc <= 16'd0;
        end else if (!stall) begin
            if (r_ex_valid && (r_ex_bs != BS_INC)) begin
                r_br_total <= r_br_total + 16'd1;
            end
            if (w_taken) begin
                r_br_taken <= r_br_taken + 16'd1;
            end
            if (w_flush) begin
                r_flush_cyc <= r_flush_cyc + 16'd1;
            end
        end
    end

    assign br_total  = r_br_total;
    assign br_taken  = r_br_taken;
    assign flush_cyc = r_flush_cyc;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Testbench for branch_ctrl: directed scenarios followed by randomized
// traffic, all checked cycle by cycle against a transaction-level model.
module tb_branch_ctrl;
    import pipe_pkg::*;

    localparam int AW = 16;
    localparam int FC = 2;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          reset;
    logic          stall;
    logic          dof_valid;
    logic [1:0]    dof_bs;
    logic          dof_ps;
    logic [AW-1:0] dof_bra;
    logic [AW-1:0] dof_raa;
    logic          ex_z;
    logic [1:0]    BS;
    logic          PS;
    logic          Z;
    logic [AW-1:0] BrA;
    logic [AW-1:0] RAA;
    logic          taken;
    state_e        o_dbg_state;
    logic [2:0]    o_dbg_cnt;
    logic          flush;
`ifdef BRANCH_CTRL_STATS_EN
    logic [15:0]   br_total;
    logic [15:0]   br_taken;
    logic [15:0]   flush_cyc;
`endif

    always #5 clk = ~clk;

    branch_ctrl #(.ADDR_W(AW), .FLUSH_CYCLES(FC)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .dof_valid   (dof_valid),
        .dof_bs      (dof_bs),
        .dof_ps      (dof_ps),
        .dof_bra     (dof_bra),
        .dof_raa     (dof_raa),
        .ex_z        (ex_z),
        .BS          (BS),
        .PS          (PS),
        .Z           (Z),
        .BrA         (BrA),
        .RAA         (RAA),
        .taken       (taken),
        .o_dbg_state (o_dbg_state),
        .o_dbg_cnt   (o_dbg_cnt),
        .flush       (flush)
`ifdef BRANCH_CTRL_STATS_EN
        ,
        .br_total    (br_total),
        .br_taken    (br_taken),
        .flush_cyc   (flush_cyc)
`endif
    );

    // ---------------- reference model ----------------
    // The EX slot as an instruction record, plus how many more flush
    // cycles are owed after the current one.
    logic          m_valid;
    logic [1:0]    m_bs;
    logic          m_ps;
    logic [AW-1:0] m_bra;
    logic [AW-1:0] m_raa;
    int            m_left;
    logic [15:0]   m_tot;
    logic [15:0]   m_tkn;
    logic [15:0]   m_fcy;
    logic          last_flush;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_bs = 2'b00; m_ps = 1'b0; m_bra = '0; m_raa = '0;
        m_left = 0; m_tot = '0; m_tkn = '0; m_fcy = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // ---------------- driver: one clock cycle ----------------
    task automatic step(input logic v, input logic [1:0] bs, input logic ps,
                        input logic [AW-1:0] bra, input logic [AW-1:0] raa,
                        input logic z, input logic st);
        logic e_taken;
        logic e_flush;
        dof_valid = v; dof_bs = bs; dof_ps = ps; dof_bra = bra; dof_raa = raa;
        ex_z = z; stall = st;
        @(negedge clk);
        // Branch semantics straight from the ISA: cond on Z xor PS, others fixed.
        e_taken = m_valid && ((m_bs == 2'b11) || (m_bs == 2'b10) ||
                              ((m_bs == 2'b01) && (z != m_ps)));
        e_flush = e_taken || (m_left > 0);
        chk("bs",    BS,    m_valid ? m_bs : 2'b00);
        chk("ps",    PS,    m_ps);
        chk("z",     Z,     m_valid & z);
        chk("bra",   BrA,   m_bra);
        chk("raa",   RAA,   m_raa);
        chk("taken", taken, e_taken);
        chk("flush", flush, e_flush);
        chk("state", o_dbg_state, (m_left > 0) ? FLUSH : RUN);
        chk("cnt",   o_dbg_cnt, m_left);
        if (m_left > 0) chk("taken_in_flush", taken, 1'b0);
`ifdef BRANCH_CTRL_STATS_EN
        chk("br_total",  br_total,  m_tot);
        chk("br_taken",  br_taken,  m_tkn);
        chk("flush_cyc", flush_cyc, m_fcy);
`endif
        last_flush = flush;
        if (!st) begin
            if (m_valid && (m_bs != 2'b00)) m_tot = m_tot + 16'd1;
            if (e_taken) m_tkn = m_tkn + 16'd1;
            if (e_flush) m_fcy = m_fcy + 16'd1;
            if (m_left > 0) m_left = m_left - 1;
            else if (e_taken) m_left = FC - 1;
            m_valid = v && !e_flush;
            m_bs = bs; m_ps = ps; m_bra = bra; m_raa = raa;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int fl_cnt;
        reset = 1'b1; stall = 1'b0; dof_valid = 1'b0; dof_bs = 2'b00; dof_ps = 1'b0;
        dof_bra = '0; dof_raa = '0; ex_z = 1'b0; last_flush = 1'b0;
        model_reset();
        #1;
        do_reset();
        idle(1);

        // Unconditional branch, wrong-path successor squashed.
        step(1'b1, 2'b11, 1'b0, 16'h0FF0, 16'h1234, 1'b0, 1'b0);
        step(1'b1, 2'b11, 1'b0, 16'hAAAA, 16'h5555, 1'b0, 1'b0);
        step(1'b1, 2'b00, 1'b0, 16'h0001, 16'h0002, 1'b0, 1'b0);
        idle(2);

        // Reset while in FLUSH.
        step(1'b1, 2'b11, 1'b0, 16'h0FF0, 16'h0000, 1'b0, 1'b0);
        step(1'b0, 2'b00, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        chk("mid_flush_state", o_dbg_state, FLUSH);
        @(posedge clk);
        #1;
        do_reset();
        idle(1);

        // Conditional branches, both polarities.
        step(1'b1, 2'b01, 1'b1, 16'h0100, 16'h0000, 1'b0, 1'b0);
        step(1'b0, 2'b00, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0); // ps=1, z=0 -> taken
        idle(2);
        step(1'b1, 2'b01, 1'b1, 16'h0200, 16'h0000, 1'b0, 1'b0);
        step(1'b0, 2'b00, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0); // ps=1, z=1 -> not taken
        idle(1);
        step(1'b1, 2'b01, 1'b0, 16'h0300, 16'h0000, 1'b0, 1'b0);
        step(1'b0, 2'b00, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0); // ps=0, z=1 -> taken
        idle(2);

        // Register jump, then the same fields marked invalid.
        step(1'b1, 2'b10, 1'b0, 16'h0000, 16'hF00F, 1'b0, 1'b0);
        idle(3);
        step(1'b0, 2'b10, 1'b0, 16'h0000, 16'hF00F, 1'b0, 1'b0);
        idle(1);

        // Taken branch held by stall for three cycles.
        step(1'b1, 2'b11, 1'b0, 16'h0ABC, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 1'b0, '0, '0, 1'b0, 1'b1);
        fl_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 2'b00, 1'b0, '0, '0, 1'b0, 1'b0);
            if (last_flush) fl_cnt++;
        end
        chk("flush_len_after_stall", fl_cnt, FC);

        // Randomized traffic with stalls and occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                     1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
            end
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- EX-stage branch resolution for the 4-stage pipeline (IF, DOF, EX, WB).
- Latches the decoded branch fields from DOF, resolves them against the EX zero flag, and drives the IF next-PC select inputs (BS, PS, Z, BrA, RAA).
- Generates a multi-cycle flush that squashes wrong-path instructions after a taken redirect.

Parameters:
- ADDR_W, 16, width of PC, BrA and RAA.
- FLUSH_CYCLES, 2, number of cycles the flush is asserted per taken redirect; legal range 1..7.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  pipeline hold; freezes all state.
- dof_valid  in  1  DOF stage holds a real instruction.
- dof_bs  in  2  decoded branch select.
- dof_ps  in  1  decoded polarity select.
- dof_bra  in  ADDR_W  computed branch target (PC+1+offset).
- dof_raa  in  ADDR_W  register A value for register jump.
- ex_z  in  1  zero flag from the EX function unit, same cycle.
- BS  out  2  to IF; forced 00 when the EX entry is invalid.
- PS  out  1  to IF; registered ex copy.
- Z  out  1  to IF; ex_z gated by EX valid, 0 when invalid.
- BrA  out  ADDR_W  to IF; registered ex copy.
- RAA  out  ADDR_W  to IF; registered ex copy.
- taken  out  1  redirect taken this cycle (combinational).
- flush  out  1  squash IF/DOF contents.

Behaviour:
- BS encoding (shared with IF):
  - 00: next PC = PC1.
  - 01: conditional branch to BrA, taken when (ex_z XOR PS) = 1. PS=0 branches on zero; PS=1 branches on non-zero.
  - 10: jump to RAA.
  - 11: unconditional branch to BrA.
- EX register:
  - Captures dof_* on the rising edge when stall=0.
  - Captured valid = dof_valid AND NOT flush.
  - When stall=1, all EX fields and state hold.
- taken = ex_valid AND (BS=11 OR BS=10 OR (BS=01 AND (ex_z XOR ex_ps))). Zero added latency: the redirect is visible to IF in the same cycle the instruction occupies EX.
- FSM states:
  - RUN: flush = taken. On taken AND NOT stall: if FLUSH_CYCLES>1, go to FLUSH with cnt = FLUSH_CYCLES-1; otherwise stay in RUN.
  - FLUSH: flush = 1. Each non-stall cycle decrements cnt. On the cycle cnt=1 and NOT stall, return to RUN.
- taken cannot assert in FLUSH, because the EX entry is squashed. If it does assert there, ignore it; a bench assertion flags it.
- Reset (any cycle, including mid-flush):
  - state = RUN, cnt = 0, ex_valid = 0.
  - All EX fields = 0, so BS=00, PS=0, Z=0, BrA=0, RAA=0, taken=0, flush=0 in the cycle after reset.
- stall and taken together: taken and flush remain asserted; the state transition is deferred until stall deasserts.
- No arithmetic on addresses; BrA/RAA pass through at ADDR_W bits unchanged.

Optional Feature:
- Macro: BRANCH_CTRL_STATS_EN.
- When defined, adds three counters:
  - br_total out 16: valid EX entries with BS≠00.
  - br_taken out 16: cycles with taken=1.
  - flush_cyc out 16: cycles with flush=1.
- Counters count only on non-stall cycles, wrap at 16'hFFFF to 0, and clear on reset.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - BS encoding constants BS_INC=2'b00, BS_COND=2'b01, BS_JMPR=2'b10, BS_BR=2'b11.
  - ADDR_W default.
  - FSM state enum {RUN, FLUSH}.
- One natural sub-module: branch_cond, the combinational taken evaluator (bs, ps, z, valid → taken), reusable by a later predictor.

Test Plan:
- Reset mid-FLUSH (cycle 1 of 2) → next cycle BS=00, flush=0, taken=0, state RUN, all outputs 0.
- dof_valid=1, bs=11, BrA=16'h0FF0 → next cycle BS=11, BrA=0FF0, taken=1, flush=1 for exactly 2 cycles. The instruction following in DOF is captured with ex_valid=0 (BS out 00).
- bs=01, ps=1, ex_z=0 → taken=1. bs=01, ps=1, ex_z=1 → taken=0, flush=0. bs=01, ps=0, ex_z=1 → taken=1.
- bs=10, RAA=16'hF00F → RAA out F00F, taken=1. With dof_valid=0 and the same fields → BS out 00, taken=0.
- Taken branch with stall=1 held 3 cycles → taken and flush stay 1 and cnt holds. After stall drops, flush lasts exactly FLUSH_CYCLES more non-stall cycles in total.
- With BRANCH_CTRL_STATS_EN: 4 branches, 3 taken → br_total=4, br_taken=3, flush_cyc=6. Preload br_total=16'hFFFF, then one more branch → br_total wraps to 0.
